fp32_mantissa_multiplier: RTL

//  Front end of the FP32 multiply path: accepts two IEEE-754 single operands via valid/ready,

---
 rtl/fpu_pkg.sv | 43 ++++
 rtl/fp32_unpack.sv | 30 +++
 rtl/fp32_mantissa_multiplier.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared FP32 field widths, state encoding and flag layout
// for the multiply front end.
package fpu_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int MANT_W = 24;
    localparam int PROD_W = 48;
    localparam int BIAS   = 127;
    localparam int FLG_W  = 5;

    localparam int FLG_NAN  = 4;
    localparam int FLG_INF  = 3;
    localparam int FLG_ZERO = 2;
    localparam int FLG_OVF  = 1;
    localparam int FLG_UNF  = 0;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } mul_state_t;

    typedef logic [FLG_W-1:0] fp_flags_t;

    // Biased exponent sum as a 10-bit signed value, wide enough
    // for the full range 0+0-bias .. 255+255-bias.
    function automatic logic signed [9:0] exp_sum(
        input logic [EXP_W-1:0] ea,
        input logic [EXP_W-1:0] eb,
        input int               bias
    );
        return $signed({2'b00, ea}) + $signed({2'b00, eb})
             - $signed(10'(bias));
    endfunction

endpackage

// File: rtl/fp32_unpack.sv
// Splits one FP32 operand into sign, exponent and 24-bit
// significand; subnormals are flushed to zero.
module fp32_unpack
    import fpu_pkg::*;
(
    input  fp32_t              op_i,
    output logic               sign_o,
    output logic [EXP_W-1:0]   exp_o,
    output logic [MANT_W-1:0]  mant_o,
    output logic               is_zero_o,
    output logic               is_inf_o,
    output logic               is_nan_o
);

    logic exp_zero;
    logic exp_ones;
    logic frac_zero;

    assign exp_zero  = (op_i.exp == '0);
    assign exp_ones  = (op_i.exp == '1);
    assign frac_zero = (op_i.frac == '0);

    assign sign_o    = op_i.sign;
    assign exp_o     = op_i.exp;
    assign mant_o    = exp_zero ? '0 : {1'b1, op_i.frac};
    assign is_zero_o = exp_zero;
    assign is_inf_o  = exp_ones && frac_zero;
    assign is_nan_o  = exp_ones && !frac_zero;

endmodule

// File: rtl/fp32_mantissa_multiplier.sv
// FP32 multiply front end: unpack, exponent sum, iterative
// shift-add significand product, special-case flags.
module fp32_mantissa_multiplier #(
    parameter int BPC  = 2,
    parameter int BIAS = 127
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sign,
    output logic [7:0]  out_e,
    output logic [47:0] out_m,
    output logic [4:0]  out_flags
);
    import fpu_pkg::*;

    localparam int N    = MANT_W / BPC;
    localparam int PP_W = MANT_W + BPC;

    mul_state_t          state_q, state_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [MANT_W-1:0]   ma_q, ma_d;
    logic [MANT_W-1:0]   mb_q, mb_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic                sign_q, sign_d;
    logic [EXP_W-1:0]    e_q, e_d;
    fp_flags_t           flg_q, flg_d;

    logic                sa, sb;
    logic [EXP_W-1:0]    ea, eb;
    logic [MANT_W-1:0]   mant_a, mant_b;
    logic                za, zb, ia, ib, na, nb;

    logic signed [9:0]   esum;
    logic                is_nan, is_inf, is_zero, special;
    logic [PP_W-1:0]     pp;
    logic [5:0]          sh;

    fp32_unpack u_unpack_a (
        .op_i      (in_a),
        .sign_o    (sa),
        .exp_o     (ea),
        .mant_o    (mant_a),
        .is_zero_o (za),
        .is_inf_o  (ia),
        .is_nan_o  (na)
    );

    fp32_unpack u_unpack_b (
        .op_i      (in_b),
        .sign_o    (sb),
        .exp_o     (eb),
        .mant_o    (mant_b),
        .is_zero_o (zb),
        .is_inf_o  (ib),
        .is_nan_o  (nb)
    );

    assign esum    = exp_sum(ea, eb, BIAS);
    assign is_nan  = na || nb || (ia && zb) || (za && ib);
    assign is_inf  = !is_nan && (ia || ib);
    assign is_zero = !is_nan && !is_inf && (za || zb);
    assign special = is_nan || is_inf || is_zero;

    // One BPC-bit slice of the multiplier times the full
    // multiplicand, placed at the slice's bit position.
    assign pp = PP_W'(mb_q[BPC-1:0]) * PP_W'(ma_q);
    assign sh = 6'(cnt_q) * 6'(BPC);

    // Next-state, operand capture and accumulate logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        acc_d   = acc_q;
        sign_d  = sign_q;
        e_d     = e_q;
        flg_d   = flg_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = MUL;
                    cnt_d   = '0;
                    ma_d    = special ? '0 : mant_a;
                    mb_d    = special ? '0 : mant_b;
                    acc_d   = '0;
                    sign_d  = sa ^ sb;
                    e_d     = esum[7:0];
                    flg_d   = '0;
                    flg_d[FLG_NAN]  = is_nan;
                    flg_d[FLG_INF]  = is_inf;
                    flg_d[FLG_ZERO] = is_zero;
                    flg_d[FLG_OVF]  = !special && (esum > 10'sd254);
                    flg_d[FLG_UNF]  = !special && (esum < 10'sd1);
                end
            end
            MUL: begin
                acc_d = acc_q + (PROD_W'(pp) << sh);
                mb_d  = mb_q >> BPC;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(N - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            acc_q   <= '0;
            sign_q  <= 1'b0;
            e_q     <= '0;
            flg_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            acc_q   <= acc_d;
            sign_q  <= sign_d;
            e_q     <= e_d;
            flg_q   <= flg_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_sign  = sign_q;
    assign out_e     = e_q;
    assign out_m     = acc_q;
    assign out_flags = flg_q;

endmodule
